frame_commit_hit_resolve: RTL and testbench

//  Downstream of both per-player next-state calculators. Once per frame it waits for both

---
 rtl/frame_commit_hit_resolve.sv | 149 ++++++++++++++
 tb/tb_frame_commit_hit_resolve.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/frame_commit_hit_resolve.sv
// frame_commit_hit_resolve: gathers both players' next state each frame, resolves hits and commits.
// Define FRAME_OVERRUN_COUNT_EN to add the saturating overrun_count output.
module frame_commit_hit_resolve #(
  parameter int PLAYER_WIDTH = 40,
  parameter int KICK_RANGE = 24,
  parameter int KICK_ACTIVE_FRAME = 2,
  parameter int GRAB_RANGE = 8,
  parameter int GRAB_ACTIVE_FRAME = 1,
  parameter int P1_START_POS = 100,
  parameter int P2_START_POS = 500,
  parameter int GATHER_TIMEOUT = 255,
  parameter int STATE_DEPTH = 3,
  parameter int SPRITE_INDEX_DEPTH = 3,
  parameter int POSITION_DEPTH = 10,
  parameter logic [STATE_DEPTH-1:0] NOTHING = STATE_DEPTH'(0),
  parameter logic [STATE_DEPTH-1:0] KICK = STATE_DEPTH'(1),
  parameter logic [STATE_DEPTH-1:0] BLOCK = STATE_DEPTH'(2),
  parameter logic [STATE_DEPTH-1:0] GRAB = STATE_DEPTH'(3),
  parameter logic [STATE_DEPTH-1:0] WIN = STATE_DEPTH'(6),
  parameter logic [STATE_DEPTH-1:0] LOSE = STATE_DEPTH'(7)
) (
  input  logic                          sys_clk,
  input  logic                          reset,
  input  logic                          frame_tick,
  input  logic                          p1_done_gen,
  input  logic [STATE_DEPTH-1:0]        p1_next_state,
  input  logic [SPRITE_INDEX_DEPTH-1:0] p1_next_sprite,
  input  logic [POSITION_DEPTH-1:0]     p1_next_position,
  input  logic                          p2_done_gen,
  input  logic [STATE_DEPTH-1:0]        p2_next_state,
  input  logic [SPRITE_INDEX_DEPTH-1:0] p2_next_sprite,
  input  logic [POSITION_DEPTH-1:0]     p2_next_position,
  output logic [STATE_DEPTH-1:0]        p1_state,
  output logic [STATE_DEPTH-1:0]        p2_state,
  output logic [SPRITE_INDEX_DEPTH-1:0] p1_sprite,
  output logic [SPRITE_INDEX_DEPTH-1:0] p2_sprite,
  output logic [POSITION_DEPTH-1:0]     p1_position,
  output logic [POSITION_DEPTH-1:0]     p2_position,
  output logic                          p1_attack_connected,
  output logic                          p2_attack_connected,
  output logic                          frame_committed,
  output logic                          round_over,
  output logic                          frame_overrun
`ifdef FRAME_OVERRUN_COUNT_EN
  ,output logic [7:0]                   overrun_count
`endif
);
  localparam int PD = POSITION_DEPTH;
  localparam int SD = SPRITE_INDEX_DEPTH;
  localparam int CW = $clog2(GATHER_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, GATHER, RESOLVE, COMMIT, OVER} fsm_t;
  fsm_t fsm;
  logic got1, got2;
  logic [CW-1:0] cnt;
  logic [STATE_DEPTH-1:0] l1_state, l2_state;
  logic [SD-1:0] l1_sprite, l2_sprite;
  logic [PD-1:0] l1_pos, l2_pos;
  logic [PD+1:0] far, near;
  logic [PD:0] gap;
  logic h1, h2, fin, busy;
  // Gap between the facing edges, clamped at zero when the sprites overlap.
  assign far = {2'b0, l2_pos};
  assign near = {2'b0, l1_pos} + (PD+2)'(PLAYER_WIDTH);
  assign gap = far >= near ? (PD+1)'(far - near) : '0;
  assign h1 = (l1_state == KICK && l1_sprite == SD'(KICK_ACTIVE_FRAME) && gap <= (PD+1)'(KICK_RANGE) && l2_state != BLOCK)
           || (l1_state == GRAB && l1_sprite == SD'(GRAB_ACTIVE_FRAME) && gap <= (PD+1)'(GRAB_RANGE));
  assign h2 = (l2_state == KICK && l2_sprite == SD'(KICK_ACTIVE_FRAME) && gap <= (PD+1)'(KICK_RANGE) && l1_state != BLOCK)
           || (l2_state == GRAB && l2_sprite == SD'(GRAB_ACTIVE_FRAME) && gap <= (PD+1)'(GRAB_RANGE));
  assign fin = l1_state == WIN || l1_state == LOSE || l2_state == WIN || l2_state == LOSE;
  assign busy = fsm == GATHER || fsm == RESOLVE || fsm == COMMIT;
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      fsm <= IDLE;
      got1 <= 1'b0;
      got2 <= 1'b0;
      cnt <= '0;
      l1_state <= NOTHING;
      l2_state <= NOTHING;
      l1_sprite <= '0;
      l2_sprite <= '0;
      l1_pos <= '0;
      l2_pos <= '0;
      p1_state <= NOTHING;
      p2_state <= NOTHING;
      p1_sprite <= '0;
      p2_sprite <= '0;
      p1_position <= PD'(P1_START_POS);
      p2_position <= PD'(P2_START_POS);
      p1_attack_connected <= 1'b0;
      p2_attack_connected <= 1'b0;
      frame_committed <= 1'b0;
      round_over <= 1'b0;
      frame_overrun <= 1'b0;
`ifdef FRAME_OVERRUN_COUNT_EN
      overrun_count <= '0;
`endif
    end else begin
      frame_committed <= 1'b0;
      if (frame_tick && busy) begin
        frame_overrun <= 1'b1;
`ifdef FRAME_OVERRUN_COUNT_EN
        overrun_count <= overrun_count + {7'd0, overrun_count != 8'hff};
`endif
      end
      case (fsm)
        IDLE: if (frame_tick) begin
          fsm <= GATHER;
          got1 <= 1'b0;
          got2 <= 1'b0;
          cnt <= '0;
        end
        GATHER: begin
          if (p1_done_gen && !got1) begin
            got1 <= 1'b1;
            l1_state <= p1_next_state;
            l1_sprite <= p1_next_sprite;
            l1_pos <= p1_next_position;
          end
          if (p2_done_gen && !got2) begin
            got2 <= 1'b1;
            l2_state <= p2_next_state;
            l2_sprite <= p2_next_sprite;
            l2_pos <= p2_next_position;
          end
          if ((got1 || p1_done_gen) && (got2 || p2_done_gen)) fsm <= RESOLVE;
          else if (cnt == CW'(GATHER_TIMEOUT)) fsm <= IDLE;
          else cnt <= cnt + CW'(1);
        end
        RESOLVE: begin
          p1_attack_connected <= h1 && !h2;
          p2_attack_connected <= h2 && !h1;
          fsm <= COMMIT;
        end
        COMMIT: begin
          p1_state <= l1_state;
          p2_state <= l2_state;
          p1_sprite <= l1_sprite;
          p2_sprite <= l2_sprite;
          p1_position <= l1_pos;
          p2_position <= l2_pos;
          frame_committed <= 1'b1;
          round_over <= fin;
          fsm <= fin ? OVER : IDLE;
        end
        default: fsm <= OVER;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_commit_hit_resolve.sv
// tb_frame_commit_hit_resolve: scoreboard bench; expected commits are queued per frame and popped on frame_committed.
module tb_frame_commit_hit_resolve;
  localparam logic [2:0] NOTHING = 3'd0, KICK = 3'd1, BLOCK = 3'd2, GRAB = 3'd3;
  localparam logic [2:0] WALK_FORWARD = 3'd4, WIN = 3'd6, LOSE = 3'd7;
  logic sys_clk, reset, frame_tick;
  logic p1_done_gen, p2_done_gen;
  logic [2:0] p1_next_state, p2_next_state, p1_next_sprite, p2_next_sprite;
  logic [9:0] p1_next_position, p2_next_position;
  logic [2:0] p1_state, p2_state, p1_sprite, p2_sprite;
  logic [9:0] p1_position, p2_position;
  logic p1_attack_connected, p2_attack_connected, frame_committed, round_over, frame_overrun;
`ifdef FRAME_OVERRUN_COUNT_EN
  logic [7:0] overrun_count;
`endif
  typedef struct {
    logic [2:0] s1, sp1;
    logic [9:0] x1;
    logic [2:0] s2, sp2;
    logic [9:0] x2;
    logic h1, h2, ro;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  frame_commit_hit_resolve dut (
    .sys_clk(sys_clk), .reset(reset), .frame_tick(frame_tick),
    .p1_done_gen(p1_done_gen), .p1_next_state(p1_next_state),
    .p1_next_sprite(p1_next_sprite), .p1_next_position(p1_next_position),
    .p2_done_gen(p2_done_gen), .p2_next_state(p2_next_state),
    .p2_next_sprite(p2_next_sprite), .p2_next_position(p2_next_position),
    .p1_state(p1_state), .p2_state(p2_state), .p1_sprite(p1_sprite), .p2_sprite(p2_sprite),
    .p1_position(p1_position), .p2_position(p2_position),
    .p1_attack_connected(p1_attack_connected), .p2_attack_connected(p2_attack_connected),
    .frame_committed(frame_committed), .round_over(round_over), .frame_overrun(frame_overrun)
`ifdef FRAME_OVERRUN_COUNT_EN
    ,.overrun_count(overrun_count)
`endif
  );
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge sys_clk) begin
    if (reset && frame_committed) begin
      if (q.size() == 0) check("spurious_commit", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("p1_state", p1_state, e.s1);
        check("p1_sprite", p1_sprite, e.sp1);
        check("p1_pos", p1_position, e.x1);
        check("p2_state", p2_state, e.s2);
        check("p2_sprite", p2_sprite, e.sp2);
        check("p2_pos", p2_position, e.x2);
        check("p1_hit", p1_attack_connected, e.h1);
        check("p2_hit", p2_attack_connected, e.h2);
        check("round_over", round_over, e.ro);
      end
    end
  end
  // P1 reports first; P2 follows d cycles later while P1's inputs are scrambled to prove they were latched.
  task automatic run_frame(input logic [2:0] s1, sp1, input logic [9:0] x1,
                           input logic [2:0] s2, sp2, input logic [9:0] x2,
                           input int d, input logic h1, h2, ro);
    int n;
    q.push_back('{s1, sp1, x1, s2, sp2, x2, h1, h2, ro});
    @(negedge sys_clk) frame_tick = 1;
    @(negedge sys_clk) frame_tick = 0;
    p1_next_state = s1; p1_next_sprite = sp1; p1_next_position = x1; p1_done_gen = 1;
    for (int i = 0; i < d; i++) begin
      @(negedge sys_clk);
      p1_next_state = ~s1; p1_next_position = x1 ^ 10'h155;
    end
    p2_next_state = s2; p2_next_sprite = sp2; p2_next_position = x2; p2_done_gen = 1;
    n = 0;
    while (!frame_committed && n < 10) begin
      @(negedge sys_clk);
      n++;
    end
    check("latency", n, 3);
    p1_done_gen = 0; p2_done_gen = 0;
    @(negedge sys_clk) check("pulse_width", frame_committed, 0);
  endtask
  initial begin
    reset = 0; frame_tick = 0; p1_done_gen = 0; p2_done_gen = 0;
    p1_next_state = 0; p1_next_sprite = 0; p1_next_position = 0;
    p2_next_state = 0; p2_next_sprite = 0; p2_next_position = 0;
    repeat (3) @(negedge sys_clk);
    reset = 1;
    @(negedge sys_clk);
    check("rst_p1_state", p1_state, NOTHING);
    check("rst_p2_sprite", p2_sprite, 0);
    check("rst_p1_pos", p1_position, 100);
    check("rst_p2_pos", p2_position, 500);
    check("rst_flags", {p1_attack_connected, p2_attack_connected, frame_committed, round_over, frame_overrun}, 0);
    run_frame(WALK_FORWARD, 0, 110, WALK_FORWARD, 0, 490, 3, 0, 0, 0);
    run_frame(KICK, 2, 100, NOTHING, 0, 160, 1, 1, 0, 0);
    run_frame(KICK, 2, 100, BLOCK, 0, 160, 2, 0, 0, 0);
    run_frame(GRAB, 1, 100, BLOCK, 0, 148, 0, 1, 0, 0);
    run_frame(NOTHING, 0, 100, KICK, 2, 164, 1, 0, 1, 0);
    run_frame(NOTHING, 0, 100, KICK, 2, 165, 1, 0, 0, 0);
    run_frame(KICK, 2, 100, KICK, 2, 150, 0, 0, 0, 0);
    run_frame(GRAB, 1, 300, NOTHING, 0, 200, 1, 1, 0, 0);
    run_frame(GRAB, 2, 100, NOTHING, 0, 148, 1, 0, 0, 0);
    // Only P1 reports: the frame must be abandoned without a commit.
    @(negedge sys_clk) frame_tick = 1;
    @(negedge sys_clk) frame_tick = 0;
    p1_next_state = KICK; p1_next_sprite = 2; p1_next_position = 100; p1_done_gen = 1;
    repeat (300) @(negedge sys_clk);
    p1_done_gen = 0;
    check("to_p1_pos", p1_position, 100);
    check("to_p2_pos", p2_position, 148);
    check("to_overrun", frame_overrun, 0);
    run_frame(WALK_FORWARD, 0, 120, WALK_FORWARD, 0, 400, 1, 0, 0, 0);
    @(negedge sys_clk) frame_tick = 1;
    @(negedge sys_clk) frame_tick = 0;
    @(negedge sys_clk) frame_tick = 1;
    @(negedge sys_clk) frame_tick = 0;
    check("overrun_set", frame_overrun, 1);
`ifdef FRAME_OVERRUN_COUNT_EN
    check("overrun_count", overrun_count, 1);
`endif
    repeat (300) @(negedge sys_clk);
    run_frame(KICK, 2, 100, NOTHING, 0, 150, 0, 1, 0, 0);
    check("overrun_sticky", frame_overrun, 1);
`ifdef FRAME_OVERRUN_COUNT_EN
    check("overrun_count_idle", overrun_count, 1);
`endif
    // Reset lands while the frame sits in RESOLVE.
    @(negedge sys_clk) frame_tick = 1;
    @(negedge sys_clk) frame_tick = 0;
    p1_next_state = KICK; p1_next_sprite = 2; p1_next_position = 100; p1_done_gen = 1;
    p2_next_state = NOTHING; p2_next_sprite = 0; p2_next_position = 150; p2_done_gen = 1;
    @(negedge sys_clk) reset = 0;
    #1;
    check("mid_rst_p1_hit", p1_attack_connected, 0);
    check("mid_rst_p1_pos", p1_position, 100);
    check("mid_rst_p2_pos", p2_position, 500);
    check("mid_rst_overrun", frame_overrun, 0);
    p1_done_gen = 0; p2_done_gen = 0;
    @(negedge sys_clk) reset = 1;
    repeat (3) @(negedge sys_clk);
    check("post_rst_p2_pos", p2_position, 500);
    run_frame(WALK_FORWARD, 0, 130, WALK_FORWARD, 0, 300, 2, 0, 0, 0);
    run_frame(WIN, 0, 200, LOSE, 0, 300, 1, 0, 0, 1);
    @(negedge sys_clk) frame_tick = 1;
    @(negedge sys_clk) frame_tick = 0;
    p1_next_state = WALK_FORWARD; p1_next_position = 50; p1_done_gen = 1;
    p2_next_state = WALK_FORWARD; p2_next_position = 60; p2_done_gen = 1;
    repeat (20) @(negedge sys_clk);
    p1_done_gen = 0; p2_done_gen = 0;
    check("over_p1_state", p1_state, WIN);
    check("over_p2_state", p2_state, LOSE);
    check("over_p1_pos", p1_position, 200);
    check("over_p2_pos", p2_position, 300);
    check("over_round", round_over, 1);
    check("over_no_overrun", frame_overrun, 0);
    check("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
